dmem_io_responder: RTL and testbench
====================================

Name: dmem_io_responder

Overview:
- Responder side of the processor data-memory port: serves dmem read/write requests from the PMIPS core.
- Contains a word RAM, a memory-mapped 7-segment display register, and two debounced slide-switch inputs.
- Sits between the core's dmem bus and board I/O (Spartan-3E switches and 7-segment display).
- Read data is combinational so the core's memory stage needs no wait states. Writes, I/O capture and debouncing are clocked.

Parameters:
- DEPTH_LOG2, 7: RAM holds 2^DEPTH_LOG2 16-bit words.
- DEBOUNCE_CYCLES, 4: consecutive synchronized cycles a switch must hold a new level before it is accepted (≥1).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- dmemaddr  in  16  byte address; bit 0 ignored.
- dmemwdata  in  16  write data.
- dmemwrite  in  1  write enable, sampled at rising edge.
- dmemread  in  1  read enable.
- dmemrdata  out  16  read data, combinational.
- io_sw0  in  1  raw switch 0, asynchronous to clock.
- io_sw1  in  1  raw switch 1, asynchronous to clock.
- io_display  out  7  segments {g,f,e,d,c,b,a}, 1 = segment lit.

Behaviour:
- Address decode:
  - I/O region is dmemaddr ≥ 16'hFFF0: 16'hFFF0 = display register; 16'hFFF2 = sw0; 16'hFFF4 = sw1; other I/O addresses are reserved.
  - All other addresses select RAM word dmemaddr[DEPTH_LOG2:1]. Upper bits are ignored, so RAM aliases modulo 2^(DEPTH_LOG2+1) bytes.
- Read (combinational):
  - dmemread=0 → dmemrdata=16'h0000.
  - RAM → current array contents.
  - Display → {12'b0, disp_reg}.
  - sw0/sw1 → {15'b0, stable_sw0/1}.
  - Reserved I/O → 0.
- Write (rising edge, dmemwrite=1):
  - RAM → word updated.
  - Display → disp_reg <= dmemwdata[3:0].
  - Switch and reserved addresses → ignored.
- Write/read same address, same cycle: dmemrdata shows old value until the edge, new value afterwards. dmemread and dmemwrite both high is legal: write performed, rdata shows old value.
- Display encoding: io_display = seg(disp_reg), combinational from the register. Hex 0-F → 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Switch path, per switch, independent:
  - Two-flop synchronizer → sync.
  - Counter cnt (width ceil(log2(DEBOUNCE_CYCLES))+1).
  - sync==stable → cnt<=0.
  - sync!=stable, cnt==DEBOUNCE_CYCLES-1 → stable<=sync, cnt<=0.
  - Otherwise cnt<=cnt+1.
  - A clean input step becomes visible on readback exactly 2+DEBOUNCE_CYCLES rising edges after it is sampled. A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes stable.
- Reset (reset=0, asynchronous):
  - disp_reg=0, so io_display=7'h3F.
  - Synchronizer flops, stable, cnt = 0.
  - RAM contents are NOT reset (undefined until written).
  - A write asserted while reset is low is dropped, including I/O writes.
  - Deassertion mid-debounce restarts counting from zero.
- No X propagation: dmemrdata is defined for every address whenever dmemread=1, except unwritten RAM.

Test Plan:
1. Reset, write 16'h1234 to 16'h0010, then read 16'h0010 with dmemread=1 → dmemrdata=16'h1234; with dmemread=0 → 16'h0000.
2. Write 16'h0007 to 16'hFFF0 → io_display=7'h07 after the edge, read of 16'hFFF0 returns 16'h0007; write 16'h000A → 7'h77.
3. DEBOUNCE_CYCLES=4: io_sw0 high for 2 cycles then low → read 16'hFFF2 stays 16'h0000. io_sw0 held high → read returns 16'h0001 exactly 6 edges after first sample. Read of 16'hFFF4 stays 0.
4. Aliasing, DEPTH_LOG2=7: write 16'hBEEF to 16'h0002, read 16'h0102 → 16'hBEEF. Write to 16'hFFF6, then read 16'hFFF6 → 0 and RAM word 16'h0006 unchanged.
5. Same-cycle read/write: RAM[16'h0004]=16'h1111, drive write 16'h2222 with read → rdata 16'h1111 before the edge, 16'h2222 after.
6. Display at 16'h0009 with io_sw1 stable high, pulse reset low mid-cycle → io_display=7'h3F immediately, sw1 reads 0 until 2+DEBOUNCE_CYCLES edges after release, a write held during reset is not applied.

Source files
------------

// File: rtl/dmem_io_responder.sv
// dmem_io_responder: data-memory responder for the core. Serves a word RAM,
// a 4-bit hex display register driving a 7-segment display, and two
// debounced slide switches. Reads are combinational (no wait states); writes,
// switch synchronisation and debouncing are clocked.
module dmem_io_responder #(
  parameter int DEPTH_LOG2      = 7,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  input  logic        io_sw0,
  input  logic        io_sw1,
  output logic [6:0]  io_display
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [15:0] ADDR_DISP = 16'hFFF0;
  localparam logic [15:0] ADDR_SW0  = 16'hFFF2;
  localparam logic [15:0] ADDR_SW1  = 16'hFFF4;

  logic [15:0]           mem [0:DEPTH-1];
  logic [3:0]            disp_reg;
  logic [1:0]            stable_sw;
  logic [1:0]            sw_raw;
  logic                  is_io;
  logic [DEPTH_LOG2-1:0] ram_idx;

  // Everything at or above FFF0 is I/O; the rest aliases onto the RAM.
  assign is_io   = (dmemaddr >= ADDR_DISP);
  assign ram_idx = dmemaddr[DEPTH_LOG2:1];
  assign sw_raw  = {io_sw1, io_sw0};

  // RAM write port; contents are not cleared, but writes during reset are dropped.
  always_ff @(posedge clock) begin
    if (reset && dmemwrite && !is_io) begin
      mem[ram_idx] <= dmemwdata;
    end
  end

  // Display register: low nibble of a write to the display address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_reg <= 4'h0;
    end else if (dmemwrite && (dmemaddr == ADDR_DISP)) begin
      disp_reg <= dmemwdata[3:0];
    end
  end

  // Per-switch synchroniser and debouncer; each switch runs independently.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sw
      logic             s1_reg;
      logic             s2_reg;
      logic             stable_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Two-flop sync, then accept a new level only after it has held long enough.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          s1_reg     <= 1'b0;
          s2_reg     <= 1'b0;
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          s1_reg <= sw_raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            stable_reg <= s2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign stable_sw[gi] = stable_reg;
    end
  endgenerate

  // Combinational read mux; idle reads and reserved I/O return zero.
  always_comb begin
    dmemrdata = 16'h0000;
    if (dmemread) begin
      if (!is_io) begin
        dmemrdata = mem[ram_idx];
      end else begin
        case (dmemaddr)
          ADDR_DISP: dmemrdata = {12'b0, disp_reg};
          ADDR_SW0:  dmemrdata = {15'b0, stable_sw[0]};
          ADDR_SW1:  dmemrdata = {15'b0, stable_sw[1]};
          default:   dmemrdata = 16'h0000;
        endcase
      end
    end
  end

  // Hex digit to active-high segments {g,f,e,d,c,b,a}.
  always_comb begin
    io_display = 7'h3F;
    case (disp_reg)
      4'h0: io_display = 7'h3F;
      4'h1: io_display = 7'h06;
      4'h2: io_display = 7'h5B;
      4'h3: io_display = 7'h4F;
      4'h4: io_display = 7'h66;
      4'h5: io_display = 7'h6D;
      4'h6: io_display = 7'h7D;
      4'h7: io_display = 7'h07;
      4'h8: io_display = 7'h7F;
      4'h9: io_display = 7'h6F;
      4'hA: io_display = 7'h77;
      4'hB: io_display = 7'h7C;
      4'hC: io_display = 7'h39;
      4'hD: io_display = 7'h5E;
      4'hE: io_display = 7'h79;
      4'hF: io_display = 7'h71;
      default: io_display = 7'h3F;
    endcase
  end

endmodule

// File: tb/tb_dmem_io_responder.sv
// Directed bench for dmem_io_responder: RAM, display, switch debounce,
// aliasing, same-cycle read/write and asynchronous reset behaviour.
module tb_dmem_io_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;
  logic        io_sw0;
  logic        io_sw1;
  logic [6:0]  io_display;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_io_responder #(.DEPTH_LOG2(7), .DEBOUNCE_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .dmemaddr   (dmemaddr),
    .dmemwdata  (dmemwdata),
    .dmemwrite  (dmemwrite),
    .dmemread   (dmemread),
    .dmemrdata  (dmemrdata),
    .io_sw0     (io_sw0),
    .io_sw1     (io_sw1),
    .io_display (io_display)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, landing 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    dmemaddr  = addr;
    dmemwdata = data;
    dmemwrite = 1'b1;
    $display("wr  addr=%h data=%h", addr, data);
    tick();
    dmemwrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    dmemaddr = addr;
    dmemread = 1'b1;
    #1;
    $display("rd  %s addr=%h data=%h exp=%h", tag, addr, dmemrdata, exp);
    check_eq(tag, dmemrdata, exp);
    dmemread = 1'b0;
  endtask

  task automatic disp(input string tag, input logic [6:0] exp);
    #1;
    $display("seg %s io_display=%h exp=%h", tag, io_display, exp);
    check_eq(tag, {9'b0, io_display}, {9'b0, exp});
  endtask

  initial begin
    reset = 1'b0; dmemaddr = '0; dmemwdata = '0; dmemwrite = 1'b0;
    dmemread = 1'b0; io_sw0 = 1'b0; io_sw1 = 1'b0;

    // Reset state
    repeat (2) tick();
    disp("rst_disp", 7'h3F);
    rd("rst_dispreg", 16'hFFF0, 16'h0000);
    rd("rst_sw0", 16'hFFF2, 16'h0000);
    rd("rst_sw1", 16'hFFF4, 16'h0000);
    reset = 1'b1;
    tick();

    // 1: RAM write/read, read enable gating
    wr(16'h0010, 16'h1234);
    rd("ram_rd", 16'h0010, 16'h1234);
    dmemaddr = 16'h0010; dmemread = 1'b0; #1;
    $display("rd  ram_noread addr=0010 data=%h exp=0000", dmemrdata);
    check_eq("ram_noread", dmemrdata, 16'h0000);

    // 2: display register and segment decode
    wr(16'hFFF0, 16'h0007);
    disp("disp_7", 7'h07);
    rd("dispreg_7", 16'hFFF0, 16'h0007);
    wr(16'hFFF0, 16'h000A);
    disp("disp_A", 7'h77);
    wr(16'hFFF0, 16'h1235);
    disp("disp_5", 7'h6D);
    rd("dispreg_5", 16'hFFF0, 16'h0005);

    // 3: glitch of two samples on sw0 is rejected
    io_sw0 = 1'b1;
    tick(); tick();
    io_sw0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      rd("sw0_glitch", 16'hFFF2, 16'h0000);
    end
    // clean step: visible exactly on the 6th edge after first sample
    io_sw0 = 1'b1;
    repeat (5) tick();
    rd("sw0_edge5", 16'hFFF2, 16'h0000);
    tick();
    rd("sw0_edge6", 16'hFFF2, 16'h0001);
    rd("sw1_still0", 16'hFFF4, 16'h0000);

    // 4: aliasing and reserved I/O
    wr(16'h0002, 16'hBEEF);
    rd("alias_0102", 16'h0102, 16'hBEEF);
    wr(16'h0006, 16'h6666);
    wr(16'hFFF6, 16'hDEAD);
    rd("resv_fff6", 16'hFFF6, 16'h0000);
    rd("ram_0006", 16'h0006, 16'h6666);
    wr(16'hFFF2, 16'h0000);
    rd("sw0_nowrite", 16'hFFF2, 16'h0001);

    // 5: same-cycle read and write
    wr(16'h0004, 16'h1111);
    dmemaddr = 16'h0004; dmemwdata = 16'h2222; dmemwrite = 1'b1; dmemread = 1'b1;
    #1;
    $display("rw  before edge data=%h exp=1111", dmemrdata);
    check_eq("rw_before", dmemrdata, 16'h1111);
    tick();
    dmemwrite = 1'b0;
    #1;
    $display("rw  after edge data=%h exp=2222", dmemrdata);
    check_eq("rw_after", dmemrdata, 16'h2222);
    dmemread = 1'b0;

    // 6: asynchronous reset mid-cycle
    wr(16'h0020, 16'hAAAA);
    wr(16'hFFF0, 16'h0009);
    disp("disp_9", 7'h6F);
    io_sw1 = 1'b1;
    repeat (8) tick();
    rd("sw1_hi", 16'hFFF4, 16'h0001);
    dmemaddr = 16'hFFF0; dmemwdata = 16'h0005; dmemwrite = 1'b1;
    #1;
    reset = 1'b0;
    disp("rst_async_disp", 7'h3F);
    tick();
    dmemaddr = 16'h0020; dmemwdata = 16'h5555;
    tick();
    dmemwrite = 1'b0;
    disp("rst_write_drop", 7'h3F);
    rd("rst_sw1_low", 16'hFFF4, 16'h0000);
    reset = 1'b1;
    disp("post_rst_disp", 7'h3F);
    rd("ram_kept", 16'h0020, 16'hAAAA);
    rd("post_rst_dispreg", 16'hFFF0, 16'h0000);
    repeat (5) tick();
    rd("sw1_rel_edge5", 16'hFFF4, 16'h0000);
    tick();
    rd("sw1_rel_edge6", 16'hFFF4, 16'h0001);
    rd("sw0_rel", 16'hFFF2, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
